// File: rtl/dm_responder_pkg.sv
// Shared types and defaults for the data-memory responder.
// Holds the FSM state encoding, the read byte-enable code and the default geometry.
package dm_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmState_t;

    localparam logic [3:0]  BYTEEN_NONE        = 4'b0000;
    localparam logic [31:0] DEFAULT_BASE_ADDR  = 32'h0000_0000;
    localparam int          DEFAULT_ADDR_WIDTH = 12;

endpackage

// File: rtl/dm_byte_merge.sv
// Combinational byte-lane merge of new write data into an existing word.
// Enabled lanes take the new data; the other lanes keep the old word.
module dm_byte_merge (
    input  logic [31:0] oldWord,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteen,
    output logic [31:0] merged
);

    always_comb begin
        merged = oldWord;
        for (int i = 0; i < 4; i++) begin
            if (byteen[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: byte-merged writes, full-word reads, programmable wait states.
// Responds with a one-cycle ready pulse and emits a trace of every committed write.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for m_data_req; request fields captured on accept
// ST_WAIT | counting down wait states; leaves for ST_RESP when counter is 1
// ST_RESP | ready pulse; read data or write trace driven, write commits at end
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_data_req,
    input  logic [31:0] m_data_addr,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_data_wdata,
    output logic [31:0] m_data_rdata,
    output logic        m_data_ready,
    output logic        m_data_err,
    output logic        wr_valid,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data
);

    localparam int          DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [32:0] SPAN  = 33'(1) << (ADDR_WIDTH + 2);

    dmState_t        state, stateNext;
    logic [3:0]      cnt, cntNext;
    logic            accept;
    logic [31:0]     reqAddr;
    logic [3:0]      reqByteen;
    logic [31:0]     reqWdata;
    logic [31:0]     rdataHold;

    logic [31:0]     mem [DEPTH];
    logic [31:0]     offset;
    logic [ADDR_WIDTH-1:0] index;
    logic            inRange;
    logic            inResp;
    logic            isRead;
    logic            respRead;
    logic            memWe;
    logic [31:0]     memWord;
    logic [31:0]     rdataResp;
    logic [31:0]     merged;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            reqAddr   <= 32'd0;
            reqByteen <= 4'd0;
            reqWdata  <= 32'd0;
            rdataHold <= 32'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (accept) begin
                reqAddr   <= m_data_addr;
                reqByteen <= m_data_byteen;
                reqWdata  <= m_data_wdata;
            end
            if (respRead) begin
                rdataHold <= rdataResp;
            end
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (m_data_req) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        stateNext = ST_WAIT;
                        cntNext   = 4'(WAIT_CYCLES);
                    end else begin
                        stateNext = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                cntNext = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    stateNext = ST_RESP;
                end
            end
            ST_RESP: stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    // Addresses below BASE_ADDR wrap to a huge offset, so the span test alone is not enough.
    assign offset  = reqAddr - BASE_ADDR;
    assign index   = offset[ADDR_WIDTH+1:2];
    assign inRange = (reqAddr >= BASE_ADDR) && ({1'b0, offset} < SPAN);

    assign memWord   = mem[index];
    assign rdataResp = inRange ? memWord : 32'd0;

    dm_byte_merge uMerge (
        .oldWord (memWord),
        .wdata   (reqWdata),
        .byteen  (reqByteen),
        .merged  (merged)
    );

    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[index] <= merged;
        end
    end

    assign inResp   = (state == ST_RESP);
    assign isRead   = (reqByteen == BYTEEN_NONE);
    assign respRead = inResp && isRead;
    assign memWe    = inResp && !isRead && inRange;

    assign m_data_ready = inResp;
    assign m_data_err   = inResp && !inRange;
    assign m_data_rdata = respRead ? rdataResp : rdataHold;
    assign wr_valid     = memWe;
    assign wr_addr      = memWe ? {reqAddr[31:2], 2'b00} : 32'd0;
    assign wr_data      = memWe ? merged : 32'd0;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: three instances with 0, 3 and 2 wait states.
// Table-driven transactions through a scoreboard queue, plus hand-written wait and reset sequences.
module tb_dm_responder;
    import dm_responder_pkg::*;

    localparam int NINST = 3;
    localparam int WC [NINST] = '{0, 3, 2};

    typedef struct {
        int          inst;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] expRd;
        logic        expErr;
        logic [31:0] expWd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst   [NINST];
    logic        req   [NINST];
    logic [31:0] addr  [NINST];
    logic [3:0]  be    [NINST];
    logic [31:0] wdata [NINST];
    logic [31:0] rdata [NINST];
    logic        ready [NINST];
    logic        err   [NINST];
    logic        wv    [NINST];
    logic [31:0] wa    [NINST];
    logic [31:0] wd    [NINST];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] lastRead [NINST];
    vec_t        vecs [$];
    vec_t        sb [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NINST; g++) begin : gInst
        dm_responder #(
            .ADDR_WIDTH  (12),
            .BASE_ADDR   (32'h0000_0000),
            .WAIT_CYCLES (WC[g])
        ) dut (
            .clk           (clk),
            .reset         (rst[g]),
            .m_data_req    (req[g]),
            .m_data_addr   (addr[g]),
            .m_data_byteen (be[g]),
            .m_data_wdata  (wdata[g]),
            .m_data_rdata  (rdata[g]),
            .m_data_ready  (ready[g]),
            .m_data_err    (err[g]),
            .wr_valid      (wv[g]),
            .wr_addr       (wa[g]),
            .wr_data       (wd[g])
        );
    end

    task automatic check(input string name, input int inst, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got=%h exp=%h", name, inst, got, exp);
        end
    endtask

    task automatic runTxn(input vec_t v);
        vec_t        e;
        int          cyc;
        bit          seen;
        logic        expWv;
        logic [31:0] expR;
        @(negedge clk);
        req[v.inst]   = 1'b1;
        addr[v.inst]  = v.addr;
        be[v.inst]    = v.be;
        wdata[v.inst] = v.wdata;
        sb.push_back(v);
        @(negedge clk);
        req[v.inst]   = 1'b0;
        addr[v.inst]  = $urandom;
        be[v.inst]    = 4'($urandom);
        wdata[v.inst] = $urandom;
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc <= 40) begin
            if (ready[v.inst]) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen) begin
            check("ready_timeout", v.inst, 32'd0, 32'd1);
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        check("latency", e.inst, 32'(cyc), 32'(1 + WC[e.inst]));
        check("err", e.inst, 32'(err[e.inst]), 32'(e.expErr));
        expWv = (e.be != BYTEEN_NONE) && !e.expErr;
        check("wr_valid", e.inst, 32'(wv[e.inst]), 32'(expWv));
        if (e.be == BYTEEN_NONE) begin
            expR = e.expErr ? 32'd0 : e.expRd;
            check("rdata", e.inst, rdata[e.inst], expR);
            lastRead[e.inst] = expR;
        end else begin
            check("rdata_hold", e.inst, rdata[e.inst], lastRead[e.inst]);
            if (expWv) begin
                check("wr_addr", e.inst, wa[e.inst], {e.addr[31:2], 2'b00});
                check("wr_data", e.inst, wd[e.inst], e.expWd);
            end
        end
        @(negedge clk);
        check("ready_pulse", e.inst, 32'(ready[e.inst]), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] mask;
        int          nReady;

        for (int i = 0; i < NINST; i++) begin
            rst[i] = 1'b1; req[i] = 1'b0; addr[i] = 32'd0; be[i] = 4'd0; wdata[i] = 32'd0;
            lastRead[i] = 32'd0;
        end

        //              inst addr          be     wdata          expRd          err   expWd
        vecs.push_back('{0, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0,         1'b0, 32'hDEAD_BEEF});
        vecs.push_back('{0, 32'h0000_0010, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'h0});
        vecs.push_back('{0, 32'h0000_0014, 4'hF, 32'h1122_3344, 32'h0,         1'b0, 32'h1122_3344});
        vecs.push_back('{0, 32'h0000_0014, 4'h4, 32'h00AB_0000, 32'h0,         1'b0, 32'h11AB_3344});
        vecs.push_back('{0, 32'h0000_0014, 4'h0, 32'h0,         32'h11AB_3344, 1'b0, 32'h0});
        vecs.push_back('{0, 32'h0000_0014, 4'h9, 32'hCC00_00DD, 32'h0,         1'b0, 32'hCCAB_33DD});
        vecs.push_back('{0, 32'h0000_0014, 4'h0, 32'h0,         32'hCCAB_33DD, 1'b0, 32'h0});
        vecs.push_back('{0, 32'h0000_0000, 4'hF, 32'h0BAD_F00D, 32'h0,         1'b0, 32'h0BAD_F00D});
        vecs.push_back('{0, 32'h0000_4000, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{0, 32'h0000_0000, 4'h0, 32'h0,         32'h0BAD_F00D, 1'b0, 32'h0});
        vecs.push_back('{0, 32'h0000_4000, 4'h0, 32'h0,         32'h0,         1'b1, 32'h0});
        vecs.push_back('{0, 32'h0000_0013, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'h0});
        vecs.push_back('{0, 32'h0000_0010, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'h0});
        vecs.push_back('{0, 32'h0000_3FFC, 4'hF, 32'h0102_0304, 32'h0,         1'b0, 32'h0102_0304});
        vecs.push_back('{0, 32'h0000_3FFC, 4'h2, 32'h0000_7700, 32'h0,         1'b0, 32'h0102_7704});
        vecs.push_back('{0, 32'h0000_3FFD, 4'h0, 32'h0,         32'h0102_7704, 1'b0, 32'h0});
        vecs.push_back('{0, 32'hFFFF_FFFC, 4'h0, 32'h0,         32'h0,         1'b1, 32'h0});
        vecs.push_back('{1, 32'h0000_0040, 4'hF, 32'h5A5A_A5A5, 32'h0,         1'b0, 32'h5A5A_A5A5});
        vecs.push_back('{1, 32'h0000_0040, 4'h0, 32'h0,         32'h5A5A_A5A5, 1'b0, 32'h0});
        vecs.push_back('{2, 32'h0000_0020, 4'hF, 32'hAAAA_5555, 32'h0,         1'b0, 32'hAAAA_5555});
        vecs.push_back('{2, 32'h0000_0020, 4'h0, 32'h0,         32'hAAAA_5555, 1'b0, 32'h0});

        repeat (3) @(negedge clk);
        for (int i = 0; i < NINST; i++) rst[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NINST; i++) begin
            check("rst_ready", i, 32'(ready[i]), 32'd0);
            check("rst_err", i, 32'(err[i]), 32'd0);
            check("rst_wr_valid", i, 32'(wv[i]), 32'd0);
            check("rst_rdata", i, rdata[i], 32'd0);
            check("rst_wr_addr", i, wa[i], 32'd0);
            check("rst_wr_data", i, wd[i], 32'd0);
        end

        foreach (vecs[k]) runTxn(vecs[k]);

        // Three wait states with req held high: ready at cycles 4 and 9 only.
        @(negedge clk);
        req[1] = 1'b1; addr[1] = 32'h0000_0040; be[1] = 4'h0;
        mask = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            mask[k] = ready[1];
            if (ready[1]) check("wait_rdata", 1, rdata[1], 32'h5A5A_A5A5);
            if (k == 6) req[1] = 1'b0;
        end
        check("wait_ready_pattern", 1, 32'(mask), 32'h0000_0210);

        // Reset while a write sits in WAIT.
        @(negedge clk);
        req[2] = 1'b1; addr[2] = 32'h0000_0020; be[2] = 4'hF; wdata[2] = 32'h1234_5678;
        @(negedge clk);
        req[2] = 1'b0;
        #2;
        rst[2] = 1'b1;
        #1;
        check("midrst_rdata", 2, rdata[2], 32'd0);
        check("midrst_ready", 2, 32'(ready[2]), 32'd0);
        check("midrst_wr_valid", 2, 32'(wv[2]), 32'd0);
        check("midrst_wr_data", 2, wd[2], 32'd0);
        lastRead[2] = 32'd0;
        @(negedge clk);
        req[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        req[2] = 1'b0;
        nReady = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ready[2]) nReady++;
        end
        check("no_ready_after_reset", 2, 32'(nReady), 32'd0);
        runTxn('{2, 32'h0000_0020, 4'h0, 32'h0, 32'hAAAA_5555, 1'b0, 32'h0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
